// File: rtl/arith_pkg.sv
// Shared arithmetic-group definitions: FSM state encoding and default operand width.
package arith_pkg;

    localparam int ARITH_W = 4;

    // Same encoding as the restoring divider FSM.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mac_if.sv
// Start/valid handshake bundle for the shift-add multiply-accumulate unit.
interface shift_add_mac_if import arith_pkg::*; #(
    parameter int W = ARITH_W
) ();

    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [W-1:0]   C;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] P;

    modport master (output start, A, B, C, input busy, valid, P);
    modport slave  (input start, A, B, C, output busy, valid, P);

endinterface

// File: rtl/mac_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high half,
// then shift the {carry, H, L} concatenation right by one bit.
module mac_step import arith_pkg::*; #(
    parameter int W = ARITH_W
) (
    input  logic [W-1:0] h,
    input  logic [W-1:0] l,
    input  logic [W-1:0] m,
    output logic [W-1:0] h_nxt,
    output logic [W-1:0] l_nxt
);

    logic [W:0] sum;

    // Carry of H+M lands in sum[W] and becomes the new MSB after the shift.
    always_comb begin
        sum            = {1'b0, h} + (l[0] ? {1'b0, m} : '0);
        {h_nxt, l_nxt} = {sum, l[W-1:1]};
    end

endmodule

// File: rtl/shift_add_mac.sv
// Sequential unsigned P = A*B + C, one partial product per clock, W clocks per op.
// Feeding {quot, divisor, rem} from the restoring divider reconstructs the dividend.
//
//  state | meaning
//  IDLE  | waiting for start; operands load on the accepting edge
//  RUN   | W shift-add iterations; last one publishes P and pulses valid
module shift_add_mac import arith_pkg::*; #(
    parameter int W = ARITH_W
) (
    input  logic          clk,
    input  logic          rst,
    shift_add_mac_if.slave bus
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  count;
    logic [W-1:0]   m_r;
    logic [W-1:0]   h_r;
    logic [W-1:0]   l_r;
    logic [W-1:0]   h_nxt;
    logic [W-1:0]   l_nxt;
    logic [2*W-1:0] p_r;
    logic           valid_r;
    logic           last;

    assign last = (count == LAST);

    mac_step #(.W(W)) u_step (
        .h     (h_r),
        .l     (l_r),
        .m     (m_r),
        .h_nxt (h_nxt),
        .l_nxt (l_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: start only matters in IDLE; RUN ends after the W-th iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: busy follows RUN, so it is already low in the valid cycle.
    always_comb begin
        bus.busy  = (state == RUN);
        bus.valid = valid_r;
        bus.P     = p_r;
    end

    // Datapath: operand capture, iteration, and result publish on the last edge only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r     <= '0;
            h_r     <= '0;
            l_r     <= '0;
            count   <= '0;
            p_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_r   <= bus.A;
                        h_r   <= bus.C;
                        l_r   <= bus.B;
                        count <= '0;
                    end
                end
                RUN: begin
                    h_r <= h_nxt;
                    l_r <= l_nxt;
                    if (last) begin
                        p_r     <= {h_nxt, l_nxt};
                        valid_r <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mac.sv
// Scoreboard bench for shift_add_mac: stimulus pushes expected {P, completion cycle},
// a monitor pops and compares whenever valid is seen.
module tb_shift_add_mac;
    import arith_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    shift_add_mac_if #(.W(W)) bus ();

    shift_add_mac #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation in value and timing.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_P", bus.P, e.p);
                    check("mon_cycle", cyc, e.cyc);
                    check("mon_busy_in_valid", bus.busy, 0);
                end
            end
        end
    end

    // Drive one start pulse; returns at the negedge after the accepting edge.
    task automatic issue(input int a, input int b, input int c, input int exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.C     = W'(c);
        sb.push_back('{p: (2*W)'(exp), cyc: cyc + 1 + W});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Full op; returns in the valid cycle.
    task automatic run_op(input int a, input int b, input int c, input int exp);
        issue(a, b, c, exp);
        repeat (W) @(negedge clk);
    endtask

    initial begin
        int c0;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C     = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_P", bus.P, 0);
        rst = 1'b1;

        // 1: basic op with busy window
        issue(7, 5, 3, 38);
        for (int i = 0; i < W; i++) begin
            check("t1_busy_run", bus.busy, 1);
            check("t1_valid_low", bus.valid, 0);
            @(negedge clk);
        end
        check("t1_busy_done", bus.busy, 0);
        check("t1_valid", bus.valid, 1);
        check("t1_P", bus.P, 38);

        // 2: carry path and zero operands
        run_op(15, 15, 15, 240);
        run_op(0, 9, 0, 0);
        run_op(9, 0, 6, 6);
        run_op(0, 0, 15, 15);

        // 3: divider round trip
        run_op(4, 3, 1, 13);
        for (int x = 0; x < 16; x++)
            for (int y = 1; y < 16; y++)
                run_op(x / y, y, x % y, x);

        // 4: start and operand churn while busy is ignored
        issue(3, 6, 2, 20);
        for (int i = 0; i < W; i++) begin
            bus.start = 1'b1;
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
            bus.C     = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("t4_valid", bus.valid, 1);
        check("t4_P_first", bus.P, 20);
        repeat (3) @(negedge clk);
        check("t4_P_hold", bus.P, 20);
        check("t4_busy_idle", bus.busy, 0);

        // 5: start held high, three back-to-back ops every W+1 clocks
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 4'd2;  bus.B = 4'd7;  bus.C = 4'd1;
        c0 = cyc;
        sb.push_back('{p: 8'd15,  cyc: c0 + 1 + W});
        sb.push_back('{p: 8'd148, cyc: c0 + 1 + W + (W + 1)});
        sb.push_back('{p: 8'd138, cyc: c0 + 1 + W + 2 * (W + 1)});
        for (int j = 0; j <= 3 * W + 2; j++) begin
            @(negedge clk);
            check("t5_busy", bus.busy,
                  (j == W || j == 2 * W + 1 || j == 3 * W + 2) ? 0 : 1);
            if (j == 0) begin
                bus.A = 4'd11; bus.B = 4'd13; bus.C = 4'd5;
            end
            if (j == W + 1) begin
                bus.A = 4'd14; bus.B = 4'd9;  bus.C = 4'd12;
            end
            if (j == 2 * W + 2) bus.start = 1'b0;
        end
        repeat (2) @(negedge clk);

        // 6: reset two clocks into an op
        issue(5, 5, 5, 30);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_valid", bus.valid, 0);
        check("t6_P", bus.P, 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * W + 2) @(negedge clk);
        check("t6_busy_after", bus.busy, 0);
        check("t6_P_after", bus.P, 0);
        run_op(2, 3, 4, 10);
        check("t6_P_new", bus.P, 10);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
